// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and register-address constants for the hazard controller.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it.
interface pipeline_hazard_ctrl_if import pipe_ctrl_pkg::*; #(parameter int PERF_W = 32);
    logic [REG_ADDR_W-1:0] id_rs_addr_i;
    logic [REG_ADDR_W-1:0] id_rt_addr_i;
    logic                  id_uses_rt_i;
    logic                  ex_memread_i;
    logic [REG_ADDR_W-1:0] ex_rt_addr_i;
    logic                  branch_taken_i;
    logic                  jump_i;
    logic                  dmem_req_i;
    logic                  dmem_ack_i;
    logic                  pc_write_o;
    logic                  if_id_stall_o;
    logic                  if_id_flush_o;
    logic                  id_ex_stall_o;
    logic                  id_ex_bubble_o;
    logic                  ex_mem_stall_o;
    logic                  mem_wb_bubble_o;
    logic [1:0]            state_o;
    logic                  halt_o;
    logic [PERF_W-1:0]     stall_cnt_o;
    logic [PERF_W-1:0]     flush_cnt_o;
    modport master (
        output id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, ex_memread_i, ex_rt_addr_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o,
               ex_mem_stall_o, mem_wb_bubble_o, state_o, halt_o, stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, ex_memread_i, ex_rt_addr_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o,
               ex_mem_stall_o, mem_wb_bubble_o, state_o, halt_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: increment-by-one counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int W = 32) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] q
);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) q <= '0;
        else if (inc_i && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, ID redirects and multi-cycle data memory.
module pipeline_hazard_ctrl import pipe_ctrl_pkg::*; #(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input logic clk_i,
    input logic rst_i,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);
    state_t      state, state_nx;
    logic [15:0] wait_cnt, wait_nx;
    logic        load_use, mem_block, freeze, redirect;
    assign load_use  = bus.ex_memread_i && bus.ex_rt_addr_i != ZERO_REG &&
                       (bus.ex_rt_addr_i == bus.id_rs_addr_i ||
                        (bus.id_uses_rt_i && bus.ex_rt_addr_i == bus.id_rt_addr_i));
    assign mem_block = bus.dmem_req_i && !bus.dmem_ack_i;
    assign freeze    = state == HALT || mem_block;
    assign redirect  = bus.branch_taken_i || bus.jump_i;
    // Reset forces the bubble pattern directly so the outputs follow rst without a clock.
    assign bus.pc_write_o      = !rst_i && !freeze && !load_use;
    assign bus.if_id_stall_o   = !rst_i && (freeze || load_use);
    assign bus.if_id_flush_o   = !rst_i && !freeze && !load_use && redirect;
    assign bus.id_ex_stall_o   = !rst_i && freeze;
    assign bus.id_ex_bubble_o  = rst_i || (!freeze && load_use);
    assign bus.ex_mem_stall_o  = !rst_i && freeze;
    assign bus.mem_wb_bubble_o = rst_i || freeze;
    assign bus.state_o         = state;
    assign bus.halt_o          = state == HALT;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    // An ack on the timeout cycle still releases to RUN.
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        if (state == RUN && mem_block) begin
            state_nx = MEM_WAIT;
            wait_nx  = 16'd1;
        end else if (state == MEM_WAIT) begin
            if (bus.dmem_ack_i) begin
                state_nx = RUN;
                wait_nx  = '0;
            end else if (wait_cnt == TIMEOUT) state_nx = HALT;
            else wait_nx = wait_cnt + 16'd1;
        end
    end
    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(!bus.pc_write_o), .q(bus.stall_cnt_o)
    );
    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(bus.if_id_flush_o), .q(bus.flush_cnt_o)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus random stimulus, scoreboard checked at negedge against a rule-level model.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 3;
    localparam int PW = 4;
    localparam int SAT = (1 << PW) - 1;
    typedef struct {
        bit rst; bit [4:0] rs; bit [4:0] rt; bit urt; bit mr; bit [4:0] ert;
        bit br; bit jmp; bit req; bit ack;
    } stim_t;
    typedef struct { logic [17:0] v; int id; } exp_t;
    logic clk = 0;
    logic rst = 1;
    exp_t q[$];
    int tests = 0, fails = 0;
    int mode = 0, start = 0, cyc = 0, sc = 0, fc = 0;
    always #5 clk = ~clk;
    pipeline_hazard_ctrl_if #(.PERF_W(PW)) bus();
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    function automatic stim_t st(bit r, bit [4:0] rs, bit [4:0] rt, bit urt, bit mr, bit [4:0] ert,
                                 bit br, bit jmp, bit req, bit ack);
        stim_t s;
        s.rst = r; s.rs = rs; s.rt = rt; s.urt = urt; s.mr = mr; s.ert = ert;
        s.br = br; s.jmp = jmp; s.req = req; s.ack = ack;
        return s;
    endfunction
    task automatic drive(input stim_t s);
        exp_t e;
        bit lu, blk, frz;
        bit [6:0] ctl;
        @(posedge clk);
        #1;
        rst = s.rst;
        bus.id_rs_addr_i = s.rs; bus.id_rt_addr_i = s.rt; bus.id_uses_rt_i = s.urt;
        bus.ex_memread_i = s.mr; bus.ex_rt_addr_i = s.ert; bus.branch_taken_i = s.br;
        bus.jump_i = s.jmp; bus.dmem_req_i = s.req; bus.dmem_ack_i = s.ack;
        if (s.rst) begin
            mode = 0; sc = 0; fc = 0;
            e.v = {7'b0000101, 2'd0, 1'b0, 4'd0, 4'd0};
        end else begin
            lu  = s.mr && s.ert != 0 && (s.ert == s.rs || (s.urt && s.ert == s.rt));
            blk = s.req && !s.ack;
            frz = mode == 2 || blk;
            // bit order: pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble
            ctl = frz ? 7'b0101011 : lu ? 7'b0100100 : (s.br || s.jmp) ? 7'b1010000 : 7'b1000000;
            e.v = {ctl, mode[1:0], mode == 2, sc[3:0], fc[3:0]};
            sc = (sc + int'(!ctl[6]) > SAT) ? SAT : sc + int'(!ctl[6]);
            fc = (fc + int'(ctl[4]) > SAT) ? SAT : fc + int'(ctl[4]);
            if (mode == 0 && blk) begin
                mode = 1; start = cyc;
            end else if (mode == 1) begin
                if (s.ack) mode = 0;
                else if (cyc - start == TO) mode = 2;
            end
        end
        e.id = cyc;
        q.push_back(e);
        cyc++;
    endtask
    initial begin
        exp_t e;
        logic [17:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                act = {bus.pc_write_o, bus.if_id_stall_o, bus.if_id_flush_o, bus.id_ex_stall_o,
                       bus.id_ex_bubble_o, bus.ex_mem_stall_o, bus.mem_wb_bubble_o,
                       bus.state_o, bus.halt_o, bus.stall_cnt_o, bus.flush_cnt_o};
                tests++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL step%0d outputs got=%b want=%b", e.id, act, e.v);
                end
            end
        end
    end
    initial begin
        stim_t idle;
        idle = st(0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(idle);
        drive(st(0, 8, 3, 1, 1, 8, 0, 0, 0, 0));
        drive(idle);
        drive(st(0, 0, 3, 1, 1, 0, 0, 0, 0, 0));
        drive(st(0, 1, 8, 0, 1, 8, 0, 0, 0, 0));
        drive(st(0, 1, 8, 1, 1, 8, 0, 0, 0, 0));
        drive(st(0, 1, 2, 1, 0, 0, 1, 0, 0, 0));
        drive(st(0, 8, 2, 1, 1, 8, 1, 0, 0, 0));
        drive(st(0, 1, 2, 1, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) drive(st(0, 1, 2, 1, 0, 0, 1, 0, 1, 0));
        drive(st(0, 1, 2, 1, 0, 0, 0, 0, 1, 1));
        drive(idle);
        drive(st(0, 1, 2, 1, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 5; i++) drive(st(0, 1, 2, 1, 0, 0, 0, 0, 1, 0));
        drive(st(0, 1, 2, 1, 0, 0, 1, 0, 0, 1));
        drive(st(0, 8, 2, 1, 1, 8, 0, 1, 0, 0));
        drive(st(1, 1, 2, 1, 0, 0, 0, 0, 1, 0));
        drive(idle);
        for (int i = 0; i < 20; i++) drive(st(0, 8, 2, 1, 1, 8, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) drive(st(0, 1, 2, 1, 0, 0, 1, 0, 0, 0));
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 400; i++)
            drive(st($urandom_range(0, 59) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1))));
        repeat (2) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
